// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) arithmetic for the decryption datapath.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  localparam int AES_NCOLS = 4;

  // InvMixColumns coefficients for row 0, MSB first: 0e 0b 0d 09
  localparam logic [31:0] INV_MIX = 32'h0e0b0d09;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant-coefficient multiply; folds to a small XOR network when b is fixed.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ pw;
      pw = xtime(pw);
    end
    gf_mul = acc;
  endfunction

endpackage

// File: rtl/inv_round_column_stage_mixcol.sv
// Combinational InvMixColumns on one 32-bit column, row 0 in the MSB byte.
// Each output row uses the coefficient set rotated right by the row index.
module inv_mix_column
  import aes_pkg::*;
(
  input  col_t col_i,
  output col_t col_o
);

  logic [7:0] r [4];
  logic [7:0] k [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      r[i] = col_i[31-8*i -: 8];
      k[i] = INV_MIX[31-8*i -: 8];
    end
  end

  always_comb begin
    col_o = '0;
    for (int i = 0; i < 4; i++) begin
      col_o[31-8*i -: 8] = gf_mul(r[0], k[(4-i)%4]) ^ gf_mul(r[1], k[(5-i)%4]) ^
                           gf_mul(r[2], k[(6-i)%4]) ^ gf_mul(r[3], k[(7-i)%4]);
    end
  end

endmodule

// File: rtl/inv_round_column_stage.sv
// AES decryption round stage: AddRoundKey on accept, then InvMixColumns a column group per cycle.
// Holds the result in DONE until out_ready; a new state can be accepted in that same cycle.
module inv_round_column_stage
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         skip_mix,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MIX  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  logic [1:0] state_q, state_d;
  logic [1:0] col_cnt_q, col_cnt_d;
  state_t     work_q, work_d;
  logic       accept;

  col_t   cols      [AES_NCOLS];
  col_t   cols_mix  [AES_NCOLS];
  col_t   mix_in    [COLS_PER_CYCLE];
  col_t   mix_out   [COLS_PER_CYCLE];
  state_t mixed;

  assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign state_out = work_q;

  always_comb begin
    for (int c = 0; c < AES_NCOLS; c++) begin
      cols[c] = work_q[127-32*c -: 32];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    assign mix_in[g] = cols[col_cnt_q + 2'(g)];
    inv_mix_column u_mix (
      .col_i(mix_in[g]),
      .col_o(mix_out[g])
    );
  end

  // Mixed columns are written back in place; the rest of the state passes through.
  always_comb begin
    for (int c = 0; c < AES_NCOLS; c++) begin
      cols_mix[c] = cols[c];
    end
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      cols_mix[col_cnt_q + 2'(g)] = mix_out[g];
    end
    mixed = '0;
    for (int c = 0; c < AES_NCOLS; c++) begin
      mixed[127-32*c -: 32] = cols_mix[c];
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    work_d    = work_q;
    case (state_q)
      ST_MIX: begin
        work_d    = mixed;
        col_cnt_d = col_cnt_q + STEP[1:0];
        if (({1'b0, col_cnt_q} + STEP) == 3'd4) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      work_d    = state_in ^ round_key;
      col_cnt_d = 2'd0;
      state_d   = skip_mix ? ST_DONE : ST_MIX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= 2'd0;
      work_q    <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      work_q    <= work_d;
    end
  end

endmodule

// File: tb/tb_inv_round_column_stage.sv
// Bench for inv_round_column_stage: three widths side by side against a matrix-level reference.
module tb_inv_round_column_stage;
  import aes_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t state_in;
  state_t round_key;
  logic   skip_mix;

  logic   in_valid_v  [3];
  logic   in_ready_v  [3];
  logic   out_valid_v [3];
  logic   out_ready_v [3];
  state_t state_out_v [3];

  int checks = 0;
  int fails  = 0;
  int cpc [3] = '{1, 2, 4};
  logic [7:0] coef [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};

  localparam state_t T1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam state_t T1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam state_t T2_IN  = 128'h71b25e43_6023a762_fefefefe_39393939;
  localparam state_t T3_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam state_t T3_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t T3_OUT = 128'h00102030_40506070_8090a0b0_c0d0e0f0;

  always #5 clk = ~clk;

  inv_round_column_stage #(.COLS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .state_in(state_in), .round_key(round_key), .skip_mix(skip_mix),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .state_out(state_out_v[0]));
  inv_round_column_stage #(.COLS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .state_in(state_in), .round_key(round_key), .skip_mix(skip_mix),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .state_out(state_out_v[1]));
  inv_round_column_stage #(.COLS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .state_in(state_in), .round_key(round_key), .skip_mix(skip_mix),
    .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]), .state_out(state_out_v[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  // Reference: key XOR, then the inverse-mix matrix applied to every column.
  function automatic state_t ref_model(input state_t s, input state_t k, input logic skip);
    state_t w, o;
    logic [7:0] r [4];
    logic [7:0] acc;
    w = s ^ k;
    if (skip) return w;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) r[i] = w[127-32*c-8*i -: 8];
      for (int i = 0; i < 4; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(r[j], coef[(j - i + 4) % 4]);
        o[127-32*c-8*i -: 8] = acc;
      end
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int d, output int lat);
    lat = 1;
    while (!out_valid_v[d] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_txn(input int d, input state_t s, input state_t k, input logic skip,
                         input state_t exp, input string tag);
    int lat;
    state_in  = s;
    round_key = k;
    skip_mix  = skip;
    out_ready_v[d] = 1'b1;
    in_valid_v[d]  = 1'b1;
    #1;
    chk({tag, " in_ready"}, 128'(in_ready_v[d]), 128'd1);
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    if (!skip) chk({tag, " busy"}, 128'(in_ready_v[d]), 128'd0);
    wait_done(d, lat);
    chk({tag, " latency"}, 128'(lat), skip ? 128'd1 : 128'(1 + 4 / cpc[d]));
    chk({tag, " data"}, state_out_v[d], exp);
    @(posedge clk); #1;
    chk({tag, " drained"}, 128'(out_valid_v[d]), 128'd0);
  endtask

  initial begin
    int lat;
    state_t held, s, k;
    logic sk;

    rst = 1'b1;
    state_in = '0; round_key = '0; skip_mix = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_v[d] = 1'b0;
      out_ready_v[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      chk("reset out_valid", 128'(out_valid_v[d]), 128'd0);
      chk("reset state_out", state_out_v[d], 128'd0);
      chk("reset in_ready", 128'(in_ready_v[d]), 128'd1);
    end

    run_txn(0, T1_IN, '0, 1'b0, T1_OUT, "t1 mix");
    run_txn(0, T2_IN, {128{1'b1}}, 1'b0, T1_OUT, "t2 ark+mix");
    run_txn(0, T3_IN, T3_KEY, 1'b1, T3_OUT, "t3 bypass");

    // Backpressure: result must hold for 10 cycles, then a same-cycle re-accept.
    state_in = T1_IN; round_key = '0; skip_mix = 1'b0;
    out_ready_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    wait_done(0, lat);
    chk("t4 latency", 128'(lat), 128'd5);
    held = state_out_v[0];
    chk("t4 result", held, T1_OUT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("t4 stable", state_out_v[0], T1_OUT);
      chk("t4 valid held", 128'(out_valid_v[0]), 128'd1);
      chk("t4 in_ready low", 128'(in_ready_v[0]), 128'd0);
    end
    state_in = T3_IN; round_key = T3_KEY; skip_mix = 1'b1;
    in_valid_v[0] = 1'b1;
    out_ready_v[0] = 1'b1;
    #1;
    chk("t4 b2b in_ready", 128'(in_ready_v[0]), 128'd1);
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    chk("t4 b2b valid", 128'(out_valid_v[0]), 128'd1);
    chk("t4 b2b data", state_out_v[0], T3_OUT);
    @(posedge clk); #1;
    chk("t4 drained", 128'(out_valid_v[0]), 128'd0);

    // Reset with the column counter at 2.
    state_in = T1_IN; round_key = '0; skip_mix = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("t5 mid-mix busy", 128'(out_valid_v[0]), 128'd0);
    rst = 1'b1;
    #1;
    chk("t5 rst out_valid", 128'(out_valid_v[0]), 128'd0);
    chk("t5 rst state_out", state_out_v[0], 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5 in_ready", 128'(in_ready_v[0]), 128'd1);
    chk("t5 no output", 128'(out_valid_v[0]), 128'd0);
    run_txn(0, T1_IN, '0, 1'b0, T1_OUT, "t5 fresh");

    run_txn(1, T1_IN, '0, 1'b0, T1_OUT, "t6 cols2");
    run_txn(2, T1_IN, '0, 1'b0, T1_OUT, "t6 cols4");

    for (int i = 0; i < 9; i++) begin
      s  = {$urandom, $urandom, $urandom, $urandom};
      k  = {$urandom, $urandom, $urandom, $urandom};
      sk = 1'($urandom_range(0, 3) == 0);
      run_txn(i % 3, s, k, sk, ref_model(s, k, sk), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
